// File: rtl/handle_fifo_ctrl.sv
// Show-ahead FIFO sequencer for an external simple dual-port RAM with registered read.
// Keeps wrap-bit pointers, drives the RAM ports and presents valid/ready handshakes plus status.
module handle_fifo_ctrl #(
    parameter int DATA_WIDTH = 40,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH:0]   usedw,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   hiwater,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    input  logic [DATA_WIDTH-1:0] ram_q
);

    logic [ADDR_WIDTH:0] wr_ptr_reg;
    logic [ADDR_WIDTH:0] rd_ptr_reg;
    logic [ADDR_WIDTH:0] rd_ptr_next;
    logic [ADDR_WIDTH:0] hiwater_reg;
    logic                q_valid_reg;
    logic                push;
    logic                pop;

    // Status decodes only from registered pointers, so in_ready never sees out_ready.
    assign usedw = wr_ptr_reg - rd_ptr_reg;
    assign full  = (wr_ptr_reg[ADDR_WIDTH] != rd_ptr_reg[ADDR_WIDTH]) &&
                   (wr_ptr_reg[ADDR_WIDTH-1:0] == rd_ptr_reg[ADDR_WIDTH-1:0]);
    assign empty = (wr_ptr_reg == rd_ptr_reg);

    assign in_ready  = !full && !reset;
    assign out_valid = q_valid_reg;
    assign out_data  = ram_q;
    assign hiwater   = hiwater_reg;

    assign push = in_valid && in_ready && !flush;
    assign pop  = q_valid_reg && out_ready && !flush && !reset;

    // The next head address goes to the RAM now so its data is on ram_q the cycle after a pop.
    assign rd_ptr_next = rd_ptr_reg + {{ADDR_WIDTH{1'b0}}, pop};

    assign ram_data  = in_data;
    assign ram_waddr = wr_ptr_reg[ADDR_WIDTH-1:0];
    assign ram_we    = push;
    assign ram_raddr = (reset || flush) ? '0 : rd_ptr_next[ADDR_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            q_valid_reg <= 1'b0;
            hiwater_reg <= '0;
        end else begin
            if (usedw > hiwater_reg) begin
                hiwater_reg <= usedw;
            end
            if (flush) begin
                wr_ptr_reg  <= '0;
                rd_ptr_reg  <= '0;
                q_valid_reg <= 1'b0;
            end else begin
                wr_ptr_reg  <= wr_ptr_reg + {{ADDR_WIDTH{1'b0}}, push};
                rd_ptr_reg  <= rd_ptr_next;
                // Compare against the pre-increment write pointer: an entry written on
                // this edge is not yet readable because the RAM returns old data on collision.
                q_valid_reg <= (rd_ptr_next != wr_ptr_reg);
            end
        end
    end

endmodule
